// File: rtl/plic_claim_initiator.sv
// Per-context PLIC claim/complete Wishbone master.
// Claims a source ID when the target line is raised, offers it to the core
// over a valid/ready port, and writes it back once the handler is done.
module plic_claim_initiator #(
   parameter int          PADDR_SIZE     = 30,
   parameter int          PDATA_SIZE     = 32,
   parameter int          CONTEXT        = 0,
   parameter logic [19:0] CLAIM_BASE     = 20'h80001,
   parameter logic [19:0] CONTEXT_STRIDE = 20'h00400,
   parameter int          TIMEOUT        = 255,
   parameter int          HOLDOFF        = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  wb_cyc,
   output logic                  wb_stb,
   output logic                  wb_we,
   output logic [PADDR_SIZE-1:0] wb_adr,
   output logic [PDATA_SIZE-1:0] wb_dat_o,
   input  logic [PDATA_SIZE-1:0] wb_dat_i,
   input  logic                  wb_ack,
   input  logic                  irq_in,
   output logic                  irq_valid,
   output logic [PDATA_SIZE-1:0] irq_id,
   input  logic                  irq_ready,
   input  logic                  done,
   output logic                  busy,
   output logic                  timeout_err,
   input  logic                  err_clr,
   output logic [15:0]           claim_count,
   output logic [15:0]           spurious_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLAIM,
      S_DELIVER,
      S_WAIT_DONE,
      S_COMPLETE
   } state_t;

   // Claim/complete register address of this context, zero-extended.
   localparam logic [31:0] ADR_FULL = 32'(CLAIM_BASE) + 32'(CONTEXT) * 32'(CONTEXT_STRIDE);
   // Last count value before a bus cycle is abandoned.
   localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0]  HOLD_LD  = 8'(HOLDOFF);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  tmo_cnt;
   logic [7:0]  hold_cnt;
   logic        claim_ack;
   logic        cmpl_ack;
   logic        tmo_abort;
   logic        done_take;
   logic        bus_enter;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign wb_adr = ADR_FULL[PADDR_SIZE-1:0];
   assign busy   = (state != S_IDLE);

   // A bus cycle starts whenever the FSM moves into CLAIM or COMPLETE.
   assign bus_enter = ((state_nxt == S_CLAIM)    && (state != S_CLAIM)) ||
                      ((state_nxt == S_COMPLETE) && (state != S_COMPLETE));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode and per-transition event strobes.
   always_comb begin
      state_nxt = state;
      claim_ack = 1'b0;
      cmpl_ack  = 1'b0;
      tmo_abort = 1'b0;
      done_take = 1'b0;
      case (state)
         S_IDLE: begin
            if (irq_in && (hold_cnt == 8'd0)) state_nxt = S_CLAIM;
         end
         S_CLAIM: begin
            if (wb_ack) begin
               claim_ack = 1'b1;
               state_nxt = (wb_dat_i == '0) ? S_IDLE : S_DELIVER;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_abort = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_DELIVER: begin
            // done arriving here is dropped; only the handshake matters.
            if (irq_valid && irq_ready) state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (done) begin
               done_take = 1'b1;
               state_nxt = S_COMPLETE;
            end
         end
         S_COMPLETE: begin
            if (wb_ack) begin
               cmpl_ack  = 1'b1;
               state_nxt = S_IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_abort = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Registered bus and handshake outputs, decoded from the upcoming state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_cyc    <= 1'b0;
         wb_stb    <= 1'b0;
         wb_we     <= 1'b0;
         irq_valid <= 1'b0;
      end else begin
         wb_cyc    <= (state_nxt == S_CLAIM) || (state_nxt == S_COMPLETE);
         wb_stb    <= (state_nxt == S_CLAIM) || (state_nxt == S_COMPLETE);
         wb_we     <= (state_nxt == S_COMPLETE);
         irq_valid <= (state_nxt == S_DELIVER);
      end
   end

   // Bus-cycle watchdog: restarts on every new cycle, counts while cyc is up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          tmo_cnt <= 8'd0;
      else if (bus_enter) tmo_cnt <= 8'd0;
      else if (wb_cyc)    tmo_cnt <= tmo_cnt + 8'd1;
   end

   // Post-completion holdoff keeps a still-high irq_in from re-claiming at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         hold_cnt <= 8'd0;
      else if (cmpl_ack || (tmo_abort && (state == S_COMPLETE)))
         hold_cnt <= HOLD_LD;
      else if ((state == S_IDLE) && (hold_cnt != 8'd0))
         hold_cnt <= hold_cnt - 8'd1;
   end

   // Claimed ID capture and completion write data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_id   <= '0;
         wb_dat_o <= '0;
      end else begin
         if (claim_ack) irq_id <= wb_dat_i;
         if (done_take)
            wb_dat_o <= irq_id;
         else if ((state == S_COMPLETE) && (state_nxt == S_IDLE))
            wb_dat_o <= '0;
      end
   end

   // Claim statistics and sticky timeout flag; a new timeout beats err_clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         claim_count    <= 16'd0;
         spurious_count <= 16'd0;
         timeout_err    <= 1'b0;
      end else begin
         if (claim_ack && (wb_dat_i != '0)) claim_count    <= sat_inc(claim_count);
         if (claim_ack && (wb_dat_i == '0)) spurious_count <= sat_inc(spurious_count);
         if (tmo_abort)    timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

endmodule
